ps2_keyboard_matrix: RTL

Converts a PS/2 keyboard (scan code set 2) into the C64 8x8 keyboard matrix and drives the `keyboard_COL` input of the c64 top level from its `keyboard_ROW` output (CIA1 port A drive lines). It holds a 64-bit pressed-key map updated from make/break codes. It answers CIA1 row scans by pulling low every column that has a pressed key on a driven-low row. RESTORE is not part of the matrix and is exported separately for the NMI path.

---
 rtl/ps2_keyboard_matrix_if.sv | 24 ++
 rtl/ps2_keyboard_matrix.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_matrix_if.sv
// PS/2 keyboard matrix bundle: raw PS/2 lines,
// CIA1 row/column lines and receiver status.
interface ps2_keyboard_matrix_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyboard_ROW;
  logic [7:0] keyboard_COL;
  logic       restore;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data, keyboard_ROW,
    input  keyboard_COL, restore, scancode,
    input  scancode_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, keyboard_ROW,
    output keyboard_COL, restore, scancode,
    output scancode_valid, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 receiver and decoder that maintains the
// C64 8x8 key matrix and answers CIA1 row scans.
module ps2_keyboard_matrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 16384
) (
  input logic dot_clk,
  input logic res_n,
  ps2_keyboard_matrix_if.slave kb
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    R_IDLE, R_SHIFT, R_CHECK
  } rx_t;

  typedef enum logic [2:0] {
    D_NORM, D_BRK, D_EXT, D_EXTBRK, D_SKIP
  } dec_t;

  // bit 0 = clock, bit 1 = data
  logic [1:0]         s1, s2, filt;
  logic [1:0][FW-1:0] fcnt;

  rx_t        rx_q, rx_n;
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic [TW-1:0] tmo;
  logic       clk_q, fall, last, ok;
  logic [10:0] frame;
  logic [7:0] sc_q;
  logic       valid_q, err_q;

  dec_t       dec_q, dec_n;
  logic [2:0] skip_q, skip_n;
  logic [63:0] keys;
  logic       restore_q;
  logic [7:0] col_q, col_n;
  logic [6:0] key;
  logic       set_k, clr_k, clr_all;
  logic       rst_set, rst_clr;

  function automatic logic [6:0] k(input int r, input int c);
    return {1'b1, 3'(r), 3'(c)};
  endfunction

  function automatic logic [6:0] map_std(input logic [7:0] c);
    logic [6:0] m;
    m = '0;
    case (c)
      8'h1C: m = k(1,2); 8'h32: m = k(3,4);
      8'h21: m = k(2,4); 8'h23: m = k(2,2);
      8'h24: m = k(1,6); 8'h2B: m = k(2,5);
      8'h34: m = k(3,2); 8'h33: m = k(3,5);
      8'h43: m = k(4,1); 8'h3B: m = k(4,2);
      8'h42: m = k(4,5); 8'h4B: m = k(5,2);
      8'h3A: m = k(4,4); 8'h31: m = k(4,7);
      8'h44: m = k(4,6); 8'h4D: m = k(5,1);
      8'h15: m = k(7,6); 8'h2D: m = k(2,1);
      8'h1B: m = k(1,5); 8'h2C: m = k(2,6);
      8'h3C: m = k(3,6); 8'h2A: m = k(3,7);
      8'h1D: m = k(1,1); 8'h22: m = k(2,7);
      8'h35: m = k(3,1); 8'h1A: m = k(1,4);
      8'h16: m = k(7,0); 8'h1E: m = k(7,3);
      8'h26: m = k(1,0); 8'h25: m = k(1,3);
      8'h2E: m = k(2,0); 8'h36: m = k(2,3);
      8'h3D: m = k(3,0); 8'h3E: m = k(3,3);
      8'h46: m = k(4,0); 8'h45: m = k(4,3);
      8'h5A: m = k(0,1); 8'h66: m = k(0,0);
      8'h05: m = k(0,4); 8'h04: m = k(0,5);
      8'h03: m = k(0,6); 8'h83: m = k(0,3);
      8'h12: m = k(1,7); 8'h59: m = k(6,4);
      8'h29: m = k(7,4); 8'h14: m = k(7,2);
      8'h76: m = k(7,7); 8'h11: m = k(7,5);
      8'h4E: m = k(5,3); 8'h55: m = k(6,5);
      8'h41: m = k(5,7); 8'h49: m = k(5,4);
      8'h4A: m = k(6,7); 8'h4C: m = k(6,2);
      8'h52: m = k(5,5); 8'h54: m = k(5,6);
      8'h5B: m = k(6,1); 8'h0E: m = k(7,1);
      8'h5D: m = k(6,0);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [6:0] map_ext(input logic [7:0] c);
    logic [6:0] m;
    m = '0;
    case (c)
      8'h74: m = k(0,2); 8'h72: m = k(0,7);
      8'h6C: m = k(6,3); 8'h14: m = k(7,2);
      8'h11: m = k(7,5); 8'h5A: m = k(0,1);
      8'h4A: m = k(6,7);
      default: m = '0;
    endcase
    return m;
  endfunction

  // synchronise and run-length filter PS/2 clock and data
  always_ff @(posedge dot_clk or negedge res_n) begin
    if (!res_n) begin
      s1   <= 2'b11;
      s2   <= 2'b11;
      filt <= 2'b11;
      fcnt <= '0;
    end else begin
      s1 <= {kb.ps2_data, kb.ps2_clk};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall  = clk_q & ~filt[0];
  assign frame = {filt[1], shreg};
  assign ok    = ~frame[0] & (^frame[9:1]) & frame[10];

  // receiver next state; last marks the stop-bit edge
  always_comb begin
    rx_n = rx_q;
    last = 1'b0;
    unique case (rx_q)
      R_IDLE:  if (fall) rx_n = R_SHIFT;
      R_SHIFT: begin
        if (fall && bit_cnt == 4'd10) begin
          rx_n = R_CHECK;
          last = 1'b1;
        end else if (!fall && tmo == TW'(TIMEOUT - 1)) begin
          rx_n = R_IDLE;
        end
      end
      R_CHECK: rx_n = R_IDLE;
      default: rx_n = R_IDLE;
    endcase
  end

  // receiver state, shift register, timeout and frame verdict
  always_ff @(posedge dot_clk or negedge res_n) begin
    if (!res_n) begin
      rx_q    <= R_IDLE;
      clk_q   <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
      tmo     <= '0;
      sc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_q    <= rx_n;
      clk_q   <= filt[0];
      valid_q <= last & ok;
      err_q   <= last & ~ok;
      if (last && ok) sc_q <= frame[8:1];
      if (fall) shreg <= {filt[1], shreg[9:1]};
      if (rx_q == R_IDLE) bit_cnt <= 4'd1;
      else if (fall) bit_cnt <= bit_cnt + 4'd1;
      if (fall || rx_q != R_SHIFT) tmo <= '0;
      else tmo <= tmo + 1'b1;
    end
  end

  // decoder: prefix tracking and matrix actions per byte
  always_comb begin
    dec_n   = dec_q;
    skip_n  = skip_q;
    key     = '0;
    set_k   = 1'b0;
    clr_k   = 1'b0;
    clr_all = 1'b0;
    rst_set = 1'b0;
    rst_clr = 1'b0;
    if (valid_q) begin
      if ((sc_q == 8'h00 || sc_q == 8'hFF) && dec_q != D_SKIP) begin
        clr_all = 1'b1;
        dec_n   = D_NORM;
      end else begin
        unique case (dec_q)
          D_NORM: begin
            case (sc_q)
              8'hE0: dec_n = D_EXT;
              8'hF0: dec_n = D_BRK;
              8'hE1: begin
                dec_n  = D_SKIP;
                skip_n = 3'd7;
              end
              8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
              default: begin
                key   = map_std(sc_q);
                set_k = key[6];
              end
            endcase
          end
          D_BRK: begin
            key   = map_std(sc_q);
            clr_k = key[6];
            dec_n = D_NORM;
          end
          D_EXT: begin
            if (sc_q == 8'hF0) begin
              dec_n = D_EXTBRK;
            end else begin
              rst_set = sc_q == 8'h7D;
              key     = map_ext(sc_q);
              set_k   = key[6];
              dec_n   = D_NORM;
            end
          end
          D_EXTBRK: begin
            rst_clr = sc_q == 8'h7D;
            key     = map_ext(sc_q);
            clr_k   = key[6];
            dec_n   = D_NORM;
          end
          D_SKIP: begin
            skip_n = skip_q - 3'd1;
            if (skip_q == 3'd1) dec_n = D_NORM;
          end
          default: dec_n = D_NORM;
        endcase
      end
    end
  end

  // decoder state, key matrix and restore flag
  always_ff @(posedge dot_clk or negedge res_n) begin
    if (!res_n) begin
      dec_q     <= D_NORM;
      skip_q    <= '0;
      keys      <= '0;
      restore_q <= 1'b0;
    end else begin
      dec_q  <= dec_n;
      skip_q <= skip_n;
      if (clr_all) begin
        keys      <= '0;
        restore_q <= 1'b0;
      end else begin
        if (set_k) keys[key[5:0]] <= 1'b1;
        if (clr_k) keys[key[5:0]] <= 1'b0;
        if (rst_set) restore_q <= 1'b1;
        if (rst_clr) restore_q <= 1'b0;
      end
    end
  end

  // column sense: low where a pressed key sits on a selected row
  always_comb begin
    col_n = 8'hFF;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (!kb.keyboard_ROW[i] && keys[i*8+j]) col_n[j] = 1'b0;
  end

  // register the column output
  always_ff @(posedge dot_clk or negedge res_n) begin
    if (!res_n) col_q <= 8'hFF;
    else col_q <= col_n;
  end

  assign kb.keyboard_COL   = col_q;
  assign kb.restore        = restore_q;
  assign kb.scancode       = sc_q;
  assign kb.scancode_valid = valid_q;
  assign kb.frame_err      = err_q;
endmodule
